alu_acc_bank: RTL and testbench
===============================

Name: alu_acc_bank

Overview:
- Successor to the single-accumulator ALU/accumulator/flags datapath.
- Holds NUM_ACC independent WIDTH-bit accumulators, each with its own carry and overflow flags.
- Executes single-cycle ALU ops plus a multi-cycle unsigned shift-add multiply, under a start/busy/done handshake.
- Sits between the control sequencer and the register file and memory paths. The operand source is selected exactly as in the existing datapath.

Parameters:
- WIDTH, 8: accumulator and operand width in bits.
- NUM_ACC, 4: number of accumulators (>=2). SEL_W = $clog2(NUM_ACC) is derived, not overridable.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request to execute op; sampled only when busy=0.
- op, input, 3: operation code.
- acc_sel, input, SEL_W: target accumulator; also selects the observed accumulator.
- data_src, input, data_src_t: operand B source (?0 mem, 01 imm, 11 reg).
- immediate, input, WIDTH: immediate operand.
- reg_out, input, WIDTH: register-file operand.
- mem_out, input, WIDTH: memory operand.
- alu_in, output, WIDTH: muxed operand B (combinational).
- acc_v, output, WIDTH: value of accumulator acc_sel (combinational read of registers).
- flag_cy, output, 1: carry of accumulator acc_sel.
- flag_o, output, 1: overflow of accumulator acc_sel.
- flag_z, output, 1: acc_v == 0 (combinational).
- flag_s, output, 1: acc_v[WIDTH-1] (combinational).
- busy, output, 1: multiply in progress (registered).
- done, output, 1: one-cycle completion pulse (registered).

Behaviour:
- Reset: all accumulators 0, all cy/ov 0, busy 0, done 0, step counter 0, FSM in IDLE. flag_z=1 and flag_s=0 for every acc_sel. Reset mid-multiply aborts it; no done is issued.
- Op codes (A = acc[acc_sel], B = alu_in):
  - 000 ADD: A+B.
  - 001 ADC: A+B+cy[sel].
  - 010 SUB: A-B; cy = borrow (A<B unsigned).
  - 011 AND, 100 OR, 101 XOR.
  - 110 LOAD: A=B.
  - 111 MUL.
- Flags:
  - ADD/ADC/SUB set cy and ov (two's-complement signed overflow).
  - AND/OR/XOR clear ov and keep cy.
  - LOAD keeps cy and ov.
  - MUL sets cy=0 and ov = (high WIDTH bits of product != 0).
- Only acc[acc_sel] and its flags change; all other accumulators hold.
- Single-cycle ops:
  - start=1 and busy=0 at edge T: result and flags written at T.
  - done=1 during cycle T..T+1, then 0. busy stays 0.
  - Back-to-back starts on consecutive cycles are legal; done stays high.
- FSM IDLE -> MUL: on start=1, op=111, busy=0 at edge T0.
  - Latch multiplicand A, multiplier B and target index, clear the 2*WIDTH product register, set counter=WIDTH and busy=1.
- MUL state:
  - Each edge adds (B bit i ? A<<i : 0) to the product, LSB first, and decrements the counter.
  - On the edge where the counter reaches 0 (T0+WIDTH), write the low WIDTH bits and flags to the latched target, busy=0, done=1 for one cycle, return to IDLE.
- While busy=1:
  - start is ignored.
  - Changes to acc_sel, op and operands have no effect on the multiply.
  - acc_v/flags show the current (old) register values of acc_sel.
- start at the edge where busy falls is ignored (busy still 1 when sampled). A start on the next edge is accepted.
- WIDTH arithmetic is modulo 2^WIDTH. Carry comes from bit WIDTH of a WIDTH+1-bit sum.

Test Plan:
- Reset, sweep acc_sel 0..3 -> acc_v=0x00, flag_z=1, flag_s=0, cy=0, o=0, busy=0, done=0.
- LOAD imm 0x7F to acc1, then ADD imm 0x01 to acc1 -> acc1=0x80, o=1, s=1, cy=0; acc0 still 0x00; done high two cycles.
- acc2=0x01, ADD imm 0xFF -> 0x00, cy=1, z=1; ADC imm 0x00 -> 0x01, cy=0. SUB 0x05-0x07 on acc0 -> 0xFE, cy=1, s=1, o=0.
- acc3=0x0C, MUL imm 0x0D -> busy 8 cycles, done one pulse, acc3=0x9C, o=0. Then MUL imm 0x10 on acc3=0x20 -> 0x00, o=1, z=1, cy=0.
- During MUL, pulse start with op=ADD and change acc_sel -> ignored, result written only to the latched target.
- Assert rst at busy cycle 4 -> busy=0 immediately, all accumulators 0, no done pulse; post-reset ADD proceeds normally.

Source files
------------

// File: rtl/alu_acc_bank_if.sv
// Sequencer-facing bus of the accumulator bank: op request, operand sources,
// observed accumulator/flags and the busy/done handshake.
interface alu_acc_bank_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_ACC = 4
);
  localparam int SEL_W = $clog2(NUM_ACC);

  // bit 0 low selects memory, 01 immediate, 11 register file
  typedef logic [1:0] data_src_t;

  logic             start;
  logic [2:0]       op;
  logic [SEL_W-1:0] acc_sel;
  data_src_t        data_src;
  logic [WIDTH-1:0] immediate;
  logic [WIDTH-1:0] reg_out;
  logic [WIDTH-1:0] mem_out;
  logic [WIDTH-1:0] alu_in;
  logic [WIDTH-1:0] acc_v;
  logic             flag_cy;
  logic             flag_o;
  logic             flag_z;
  logic             flag_s;
  logic             busy;
  logic             done;

  modport master (
    output start, op, acc_sel, data_src, immediate, reg_out, mem_out,
    input  alu_in, acc_v, flag_cy, flag_o, flag_z, flag_s, busy, done
  );

  modport slave (
    input  start, op, acc_sel, data_src, immediate, reg_out, mem_out,
    output alu_in, acc_v, flag_cy, flag_o, flag_z, flag_s, busy, done
  );
endinterface

// File: rtl/alu_acc_bank.sv
// Bank of NUM_ACC accumulators with per-accumulator carry/overflow flags,
// single-cycle ALU ops and a WIDTH-cycle LSB-first shift-add multiply.
module alu_acc_bank #(
  parameter int WIDTH   = 8,
  parameter int NUM_ACC = 4
) (
  input logic           clk,
  input logic           rst,
  alu_acc_bank_if.slave bus
);
  // state  | meaning
  // S_IDLE | start accepted; ALU ops complete on the accepting edge
  // S_MUL  | shift-add multiply running; start and bus inputs ignored
  localparam int SEL_W = $clog2(NUM_ACC);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADC  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_LOAD = 3'b110,
    OP_MUL  = 3'b111
  } op_t;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q [NUM_ACC];
  logic [NUM_ACC-1:0] cy_q, ov_q;
  logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [SEL_W-1:0]   tgt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic               issue_alu, issue_mul, mul_last;
  logic [WIDTH-1:0]   op_a, op_b, alu_res;
  logic               alu_cy, alu_ov;
  logic [WIDTH:0]     ext;

  always_comb begin
    op_b = bus.mem_out;
    if (bus.data_src[0]) op_b = bus.data_src[1] ? bus.reg_out : bus.immediate;
  end

  assign op_a        = acc_q[bus.acc_sel];
  assign bus.alu_in  = op_b;
  assign bus.acc_v   = op_a;
  assign bus.flag_cy = cy_q[bus.acc_sel];
  assign bus.flag_o  = ov_q[bus.acc_sel];
  assign bus.flag_z  = (op_a == '0);
  assign bus.flag_s  = op_a[MSB];
  assign bus.busy    = (state_q == S_MUL);
  assign bus.done    = done_q;

  always_comb begin
    ext     = '0;
    alu_res = op_a;
    alu_cy  = cy_q[bus.acc_sel];
    alu_ov  = ov_q[bus.acc_sel];
    case (op_t'(bus.op))
      OP_ADD, OP_ADC: begin
        ext     = {1'b0, op_a} + {1'b0, op_b} +
                  {{WIDTH{1'b0}}, (op_t'(bus.op) == OP_ADC) & cy_q[bus.acc_sel]};
        alu_res = ext[WIDTH-1:0];
        alu_cy  = ext[WIDTH];
        alu_ov  = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        ext     = {1'b0, op_a} - {1'b0, op_b};
        alu_res = ext[WIDTH-1:0];
        alu_cy  = ext[WIDTH];
        alu_ov  = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_AND: begin alu_res = op_a & op_b; alu_ov = 1'b0; end
      OP_OR:  begin alu_res = op_a | op_b; alu_ov = 1'b0; end
      OP_XOR: begin alu_res = op_a ^ op_b; alu_ov = 1'b0; end
      OP_LOAD: alu_res = op_b;
      OP_MUL: ;
    endcase
  end

  assign prod_d = prod_q + (mplr_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    issue_alu = 1'b0;
    issue_mul = 1'b0;
    mul_last  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (op_t'(bus.op) == OP_MUL) begin
            issue_mul = 1'b1;
            state_d   = S_MUL;
          end else begin
            issue_alu = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(1)) begin
          mul_last = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      cy_q    <= '0;
      ov_q    <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= issue_alu | mul_last;
      if (issue_alu) begin
        acc_q[bus.acc_sel] <= alu_res;
        cy_q[bus.acc_sel]  <= alu_cy;
        ov_q[bus.acc_sel]  <= alu_ov;
      end
      if (issue_mul) begin
        mcand_q <= {{WIDTH{1'b0}}, op_a};
        mplr_q  <= op_b;
        tgt_q   <= bus.acc_sel;
        prod_q  <= '0;
        cnt_q   <= CNT_W'(WIDTH);
      end else if (state_q == S_MUL) begin
        // multiplicand moves left as multiplier bits are consumed LSB first
        prod_q  <= prod_d;
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_q >> 1;
        cnt_q   <= cnt_q - CNT_W'(1);
        if (mul_last) begin
          acc_q[tgt_q] <= prod_d[WIDTH-1:0];
          cy_q[tgt_q]  <= 1'b0;
          ov_q[tgt_q]  <= |prod_d[2*WIDTH-1:WIDTH];
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_acc_bank.sv
// Scoreboard bench for alu_acc_bank: the driver pushes the expected bank state
// for every accepted op, a monitor pops and compares it on each done cycle.
module tb_alu_acc_bank;
  localparam int WIDTH   = 8;
  localparam int NUM_ACC = 4;
  localparam int SEL_W   = 2;
  localparam int FULL    = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_acc_bank_if #(.WIDTH(WIDTH), .NUM_ACC(NUM_ACC)) bus ();
  alu_acc_bank #(.WIDTH(WIDTH), .NUM_ACC(NUM_ACC)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [NUM_ACC-1:0][WIDTH-1:0] v;
    logic [NUM_ACC-1:0]            cy;
    logic [NUM_ACC-1:0]            ov;
  } snap_t;

  snap_t exp_q[$];
  int    m_acc[NUM_ACC];
  int    m_cy[NUM_ACC];
  int    m_ov[NUM_ACC];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_s(input int x);
    return (x >= FULL / 2) ? x - FULL : x;
  endfunction

  function automatic int pick_b(input int src, input int imm, input int rv, input int mv);
    if (src % 2 == 0) return mv;
    return (src == 1) ? imm : rv;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_ACC; i++) begin
      m_acc[i] = 0; m_cy[i] = 0; m_ov[i] = 0;
    end
  endtask

  // Reference: plain integer arithmetic on the selected accumulator
  task automatic model_apply(input int opc, input int sel, input int b);
    int a, r, sr, cin;
    snap_t s;
    a   = m_acc[sel];
    cin = (opc == 1) ? m_cy[sel] : 0;
    r   = a;
    case (opc)
      0, 1: begin
        r  = a + b + cin;
        sr = to_s(a) + to_s(b) + cin;
        m_cy[sel] = (r >= FULL) ? 1 : 0;
        m_ov[sel] = (sr >= FULL / 2 || sr < -FULL / 2) ? 1 : 0;
      end
      2: begin
        r  = a - b;
        sr = to_s(a) - to_s(b);
        m_cy[sel] = (a < b) ? 1 : 0;
        m_ov[sel] = (sr >= FULL / 2 || sr < -FULL / 2) ? 1 : 0;
      end
      3: begin r = a & b; m_ov[sel] = 0; end
      4: begin r = a | b; m_ov[sel] = 0; end
      5: begin r = a ^ b; m_ov[sel] = 0; end
      6: r = b;
      default: begin
        r = a * b;
        m_cy[sel] = 0;
        m_ov[sel] = (r >= FULL) ? 1 : 0;
      end
    endcase
    m_acc[sel] = ((r % FULL) + FULL) % FULL;
    for (int i = 0; i < NUM_ACC; i++) begin
      s.v[i]  = WIDTH'(m_acc[i]);
      s.cy[i] = m_cy[i][0];
      s.ov[i] = m_ov[i][0];
    end
    exp_q.push_back(s);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 32'(bus.done), 32'(0));
      end else begin
        snap_t s;
        int    e;
        s = exp_q.pop_front();
        e = int'(s.v[bus.acc_sel]);
        chk("sb_acc_v", 32'(bus.acc_v), 32'(e));
        chk("sb_cy", 32'(bus.flag_cy), 32'(s.cy[bus.acc_sel]));
        chk("sb_ov", 32'(bus.flag_o), 32'(s.ov[bus.acc_sel]));
        chk("sb_z", 32'(bus.flag_z), 32'(e == 0));
        chk("sb_s", 32'(bus.flag_s), 32'(e >= FULL / 2));
      end
    end
  end

  // While busy, bus inputs (including start) are scrambled to show they are ignored
  task automatic issue(input int opc, input int sel, input int src,
                       input int imm, input int rv, input int mv);
    int guard = 0;
    while (bus.busy === 1'b1 && guard < 64) begin
      bus.start     = 1'($urandom);
      bus.op        = 3'($urandom);
      bus.acc_sel   = SEL_W'($urandom);
      bus.immediate = WIDTH'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 64) chk("busy_timeout", 32'(bus.busy), 32'(0));
    bus.start     = 1'b1;
    bus.op        = 3'(opc);
    bus.acc_sel   = SEL_W'(sel);
    bus.data_src  = 2'(src);
    bus.immediate = WIDTH'(imm);
    bus.reg_out   = WIDTH'(rv);
    bus.mem_out   = WIDTH'(mv);
    model_apply(opc, sel, pick_b(src, imm, rv, mv));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 50) chk("idle_timeout", 32'(bus.busy), 32'(0));
  endtask

  task automatic peek(input string name, input int sel, input int v, input int cy, input int ov);
    @(negedge clk);
    bus.acc_sel = SEL_W'(sel);
    #1;
    chk({name, "_v"}, 32'(bus.acc_v), 32'(v));
    chk({name, "_cy"}, 32'(bus.flag_cy), 32'(cy));
    chk({name, "_o"}, 32'(bus.flag_o), 32'(ov));
    chk({name, "_z"}, 32'(bus.flag_z), 32'(v == 0));
    chk({name, "_s"}, 32'(bus.flag_s), 32'(v >= FULL / 2));
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < NUM_ACC; i++) begin
      bus.acc_sel = SEL_W'(i);
      #1;
      chk({name, "_acc_v"}, 32'(bus.acc_v), 32'(0));
      chk({name, "_z"}, 32'(bus.flag_z), 32'(1));
      chk({name, "_s"}, 32'(bus.flag_s), 32'(0));
      chk({name, "_cy"}, 32'(bus.flag_cy), 32'(0));
      chk({name, "_o"}, 32'(bus.flag_o), 32'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.op        = 3'd0;
    bus.acc_sel   = '0;
    bus.data_src  = 2'b01;
    bus.immediate = '0;
    bus.reg_out   = '0;
    bus.mem_out   = '0;
    model_reset();
    #12;
    sweep_zero("reset");
    chk("reset_busy", 32'(bus.busy), 32'(0));
    chk("reset_done", 32'(bus.done), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // operand source mux
    bus.immediate = 8'hA1; bus.reg_out = 8'hB2; bus.mem_out = 8'hC3;
    for (int s = 0; s < 4; s++) begin
      bus.data_src = 2'(s);
      #1;
      chk("alu_in_mux", 32'(bus.alu_in), 32'((s == 1) ? 8'hA1 : (s == 3) ? 8'hB2 : 8'hC3));
    end

    // signed overflow into acc1, back-to-back done
    issue(6, 1, 1, 8'h7F, 0, 0);
    chk("done_first", 32'(bus.done), 32'(1));
    issue(0, 1, 1, 8'h01, 0, 0);
    chk("done_b2b", 32'(bus.done), 32'(1));
    @(posedge clk); #1;
    chk("done_drop", 32'(bus.done), 32'(0));
    peek("add_ovf", 1, 8'h80, 0, 1);
    peek("acc0_hold", 0, 8'h00, 0, 0);

    // carry chain and borrow
    issue(6, 2, 1, 8'h01, 0, 0);
    issue(0, 2, 1, 8'hFF, 0, 0);
    peek("add_carry", 2, 8'h00, 1, 0);
    issue(1, 2, 1, 8'h00, 0, 0);
    peek("adc", 2, 8'h01, 0, 0);
    issue(6, 0, 3, 8'h00, 8'h05, 0);
    issue(2, 0, 1, 8'h07, 0, 0);
    peek("sub_borrow", 0, 8'hFE, 1, 0);

    // multiply: busy for WIDTH cycles, single done pulse
    issue(6, 3, 1, 8'h0C, 0, 0);
    issue(7, 3, 1, 8'h0D, 0, 0);
    wait_idle(n);
    chk("mul_busy_cycles", 32'(n), 32'(WIDTH));
    chk("mul_done", 32'(bus.done), 32'(1));
    @(posedge clk); #1;
    chk("mul_done_pulse", 32'(bus.done), 32'(0));
    peek("mul_small", 3, 8'h9C, 0, 0);
    issue(6, 3, 1, 8'h20, 0, 0);
    issue(7, 3, 1, 8'h10, 0, 0);
    wait_idle(n);
    peek("mul_ovf", 3, 8'h00, 0, 1);

    // starts during the multiply, including the edge where busy falls, are dropped
    issue(6, 0, 1, 8'h11, 0, 0);
    issue(6, 3, 1, 8'h05, 0, 0);
    issue(7, 3, 1, 8'h03, 0, 0);
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      bus.start     = 1'b1;
      bus.op        = 3'd0;
      bus.data_src  = 2'b01;
      bus.acc_sel   = SEL_W'($urandom);
      bus.immediate = WIDTH'($urandom_range(1, 255));
      n++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("ign_busy_cycles", 32'(n), 32'(WIDTH));
    peek("ign_target", 3, 8'h0F, 0, 0);
    peek("ign_acc0", 0, 8'h11, 1, 0);
    peek("ign_acc2", 2, 8'h01, 0, 0);

    // reset in the middle of a multiply
    issue(6, 2, 1, 8'h33, 0, 0);
    issue(7, 2, 1, 8'h03, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_busy", 32'(bus.busy), 32'(1));
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    sweep_zero("midrst");
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    issue(0, 1, 1, 8'h05, 0, 0);
    peek("post_rst_add", 1, 8'h05, 0, 0);

    // randomized traffic against the reference model
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue($urandom_range(0, 7), $urandom_range(0, NUM_ACC - 1), $urandom_range(0, 3),
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    wait_idle(n);
    repeat (3) begin @(posedge clk); #1; end
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
